amiq_i2c_slave_regfile: RTL and testbench

AMIQ_I2C_SLAVE_REGFILE -- requirements
Module: amiq_i2c_slave_regfile

---
 rtl/amiq_i2c_slave_pkg.sv | 10 +
 rtl/amiq_i2c_bus_mon.sv | 29 ++
 rtl/amiq_i2c_slave_regfile.sv | 142 ++++++++++++++
 tb/tb_amiq_i2c_slave_regfile.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/amiq_i2c_slave_pkg.sv
// amiq_i2c_slave_pkg: FSM states and bus constants shared by the I2C slave register file
package amiq_i2c_slave_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
   } state_t;
   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/amiq_i2c_bus_mon.sv
// amiq_i2c_bus_mon: synchronizes SCL/SDA and flags SCL edges and START/STOP conditions
module amiq_i2c_bus_mon (
   input  logic clock,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   // [1] is the synchronized level, [2] its one-cycle history for edge detection
   logic [2:0] scl_q, sda_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end
   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/amiq_i2c_slave_regfile.sv
// amiq_i2c_slave_regfile: I2C slave exposing NUM_REGS byte registers behind an auto-incrementing pointer
module amiq_i2c_slave_regfile
   import amiq_i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NUM_REGS   = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_o_en,
   output logic                        busy,
   output logic                        wr_strobe,
   output logic                        rd_strobe,
   output logic [$clog2(NUM_REGS)-1:0] reg_addr,
   output logic [7:0]                  reg_wdata
);
   localparam int PW = $clog2(NUM_REGS);
   state_t        state;
   logic [3:0]    cnt;
   logic [7:0]    shreg;
   logic [6:0]    tx;
   logic          ack_bit;
   logic [PW-1:0] ptr, nxt, rd_idx;
   logic [7:0]    regs [NUM_REGS];
   logic          scl_rise, scl_fall, start_det, stop_det, sda_s, byte_done;

   amiq_i2c_bus_mon u_mon (
      .clock     (clock),
      .reset     (reset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   // a load from RD_ACK fetches the next register, from ADDR_ACK the current one
   always_comb begin
      nxt       = ptr + 1'b1;
      rd_idx    = (state == RD_ACK) ? nxt : ptr;
      byte_done = (cnt == 4'd8);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         tx        <= '0;
         ack_bit   <= NACK;
         ptr       <= '0;
         sda_o_en  <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         if (start_det) begin
            state    <= ADDR;
            cnt      <= '0;
            sda_o_en <= 1'b0;
         end else if (stop_det) begin
            state    <= IDLE;
            cnt      <= '0;
            sda_o_en <= 1'b0;
            busy     <= 1'b0;
         end else if (scl_rise) begin
            if (state inside {ADDR, PTR, WDATA, RDATA}) begin
               shreg <= {shreg[6:0], sda_s};
               cnt   <= cnt + 1'b1;
            end
            if (state == RD_ACK) ack_bit <= sda_s;
         end else if (scl_fall) begin
            case (state)
               ADDR: if (byte_done) begin
                  cnt <= '0;
                  if (shreg[7:1] == SLAVE_ADDR) begin
                     state    <= ADDR_ACK;
                     sda_o_en <= 1'b1;
                     busy     <= 1'b1;
                  end else state <= IGNORE;
               end
               ADDR_ACK: if (shreg[0] == RW_READ) begin
                  state     <= RDATA;
                  tx        <= regs[rd_idx][6:0];
                  sda_o_en  <= ~regs[rd_idx][7];
                  rd_strobe <= 1'b1;
                  reg_addr  <= rd_idx;
               end else begin
                  state    <= PTR;
                  sda_o_en <= 1'b0;
               end
               PTR: if (byte_done) begin
                  cnt      <= '0;
                  ptr      <= shreg[PW-1:0];
                  sda_o_en <= 1'b1;
                  state    <= PTR_ACK;
               end
               PTR_ACK, WDATA_ACK: begin
                  sda_o_en <= 1'b0;
                  state    <= WDATA;
               end
               WDATA: if (byte_done) begin
                  cnt        <= '0;
                  regs[ptr]  <= shreg;
                  wr_strobe  <= 1'b1;
                  reg_addr   <= ptr;
                  reg_wdata  <= shreg;
                  ptr        <= nxt;
                  sda_o_en   <= 1'b1;
                  state      <= WDATA_ACK;
               end
               RDATA: if (byte_done) begin
                  cnt      <= '0;
                  sda_o_en <= 1'b0;
                  state    <= RD_ACK;
               end else begin
                  sda_o_en <= ~tx[6];
                  tx       <= {tx[5:0], 1'b0};
               end
               RD_ACK: if (ack_bit == ACK) begin
                  state     <= RDATA;
                  ptr       <= nxt;
                  tx        <= regs[rd_idx][6:0];
                  sda_o_en  <= ~regs[rd_idx][7];
                  rd_strobe <= 1'b1;
                  reg_addr  <= rd_idx;
               end else state <= IGNORE;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_amiq_i2c_slave_regfile.sv
// tb_amiq_i2c_slave_regfile: I2C master bench with a register-file reference model
module tb_amiq_i2c_slave_regfile;
   import amiq_i2c_slave_pkg::*;
   localparam int H = 8;
   logic clock = 0, reset = 0, scl = 1, sda_m = 1;
   logic sda_o_en, busy, wr_strobe, rd_strobe;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata;
   wire sda_bus = sda_m & ~sda_o_en;

   amiq_i2c_slave_regfile dut (
      .clock(clock), .reset(reset), .scl_i(scl), .sda_i(sda_bus),
      .sda_o_en(sda_o_en), .busy(busy), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata)
   );

   always #5 clock = ~clock;

   logic [3:0] wa_q[$], ra_q[$], ewa[$], era[$];
   logic [7:0] wd_q[$], ewd[$];
   int drive_cnt = 0, busy_cnt = 0;
   always @(negedge clock) begin
      if (wr_strobe) begin wa_q.push_back(reg_addr); wd_q.push_back(reg_wdata); end
      if (rd_strobe) ra_q.push_back(reg_addr);
      if (sda_o_en) drive_cnt++;
      if (busy) busy_cnt++;
   end

   logic [7:0] m_regs [16];
   logic [3:0] m_ptr;
   logic [7:0] q[$];
   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_c(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic i2c_start;
      sda_m = 1; wait_c(H/2); scl = 1; wait_c(H); sda_m = 0; wait_c(H); scl = 0;
   endtask

   task automatic i2c_stop;
      wait_c(H/2); sda_m = 0; wait_c(H/2); scl = 1; wait_c(H); sda_m = 1; wait_c(H);
   endtask

   task automatic xfer_bit(input logic b, output logic r);
      wait_c(H/2); sda_m = b; wait_c(H/2); scl = 1; wait_c(H/2); r = sda_bus; wait_c(H/2); scl = 0;
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
      xfer_bit(1'b1, ack);
   endtask

   task automatic rbyte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
      xfer_bit(mack, r);
   endtask

   task automatic cmp_strobes(input string tag);
      check({tag, "_wr_count"}, wa_q.size(), ewa.size());
      for (int i = 0; i < ewa.size() && i < wa_q.size(); i++) begin
         check({tag, "_wr_addr"}, wa_q[i], ewa[i]);
         check({tag, "_wr_data"}, wd_q[i], ewd[i]);
      end
      check({tag, "_rd_count"}, ra_q.size(), era.size());
      for (int i = 0; i < era.size() && i < ra_q.size(); i++) check({tag, "_rd_addr"}, ra_q[i], era[i]);
      wa_q.delete(); wd_q.delete(); ra_q.delete(); ewa.delete(); ewd.delete(); era.delete();
   endtask

   task automatic do_write(input logic [7:0] p, input logic [7:0] data[$]);
      logic a;
      i2c_start;
      wbyte(8'hA0, a); check("wr_addr_ack", a, ACK);
      check("busy_active", busy, 1'b1);
      wbyte(p, a); check("wr_ptr_ack", a, ACK);
      m_ptr = p[3:0];
      foreach (data[i]) begin
         wbyte(data[i], a); check("wr_data_ack", a, ACK);
         m_regs[m_ptr] = data[i]; ewa.push_back(m_ptr); ewd.push_back(data[i]); m_ptr++;
      end
      i2c_stop;
      check("busy_after_stop", busy, 1'b0);
      cmp_strobes("write");
   endtask

   task automatic do_read(input logic use_ptr, input logic [7:0] p, input int n);
      logic a;
      logic [7:0] d;
      i2c_start;
      if (use_ptr) begin
         wbyte(8'hA0, a); check("rd_waddr_ack", a, ACK);
         wbyte(p, a); check("rd_ptr_ack", a, ACK);
         m_ptr = p[3:0];
         i2c_start;
      end
      wbyte(8'hA1, a); check("rd_addr_ack", a, ACK);
      for (int i = 0; i < n; i++) begin
         rbyte((i < n - 1) ? ACK : NACK, d);
         check("rd_data", d, m_regs[m_ptr]);
         era.push_back(m_ptr);
         if (i < n - 1) m_ptr++;
      end
      i2c_stop;
      cmp_strobes("read");
   endtask

   initial begin
      logic a, r;
      int d0, b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      reset = 1;
      wait_c(3);
      reset = 0;
      wait_c(2);
      check("rst_sda_o_en", sda_o_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_strobe", wr_strobe, 1'b0);
      check("rst_rd_strobe", rd_strobe, 1'b0);
      check("rst_reg_addr", reg_addr, 4'h0);
      check("rst_reg_wdata", reg_wdata, 8'h00);

      q = {8'h5A, 8'hC3};
      do_write(8'h03, q);
      do_read(1'b1, 8'h03, 2);

      q = {8'h11, 8'h22};
      do_write(8'h0F, q);
      check("wrap_ptr_model", m_ptr, 4'h1);
      do_read(1'b1, 8'h0F, 2);

      d0 = drive_cnt; b0 = busy_cnt;
      i2c_start;
      wbyte(8'hA2, a); check("badaddr_nack", a, NACK);
      wbyte(8'h12, a); check("badaddr_data_nack", a, NACK);
      i2c_stop;
      check("badaddr_no_drive", drive_cnt - d0, 0);
      check("badaddr_no_busy", busy_cnt - b0, 0);
      cmp_strobes("badaddr");

      i2c_start;
      wbyte(8'hA0, a); check("part_addr_ack", a, ACK);
      wbyte(8'h05, a); check("part_ptr_ack", a, ACK);
      m_ptr = 4'h5;
      for (int i = 0; i < 4; i++) xfer_bit(1'b0, r);
      i2c_stop;
      check("part_busy", busy, 1'b0);
      check("part_sda", sda_o_en, 1'b0);
      check("part_idle", dut.state, IDLE);
      cmp_strobes("partial");
      do_read(1'b0, 8'h00, 2);

      for (int it = 0; it < 12; it++) begin
         q.delete();
         for (int k = $urandom_range(0, 4); k > 0; k--) q.push_back(8'($urandom));
         do_write(8'($urandom), q);
         do_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 4));
      end

      q = {8'h00};
      do_write(8'h07, q);
      i2c_start;
      wbyte(8'hA0, a); wbyte(8'h07, a);
      i2c_start;
      wbyte(8'hA1, a); check("rst_test_addr_ack", a, ACK);
      for (int i = 0; i < 3; i++) xfer_bit(1'b1, r);
      wait_c(H - 2);
      check("rst_test_bit_driven", sda_o_en, 1'b1);
      #2 reset = 1;
      #1 check("rst_async_release", sda_o_en, 1'b0);
      check("rst_async_busy", busy, 1'b0);
      wait_c(3);
      reset = 0;
      sda_m = 1;
      wait_c(H);
      scl = 1;
      wait_c(2 * H);
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      wa_q.delete(); wd_q.delete(); ra_q.delete();
      do_read(1'b0, 8'h00, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
